// File: rtl/vga_sync_decoder.sv
`default_nettype none
// ============================================================================
// Module      : vga_sync_decoder
// Description : Decodes an HS/VS/Vde pixel stream. Locks onto the expected
//               line and frame timing, emits active pixel coordinates with the
//               registered colour, and produces a per-frame colour checksum.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_decoder #(
    parameter int H_TOTAL         = 800,
    parameter int H_ACTIVE        = 640,
    parameter int V_TOTAL         = 525,
    parameter int V_ACTIVE        = 480,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        HS,
    input  logic        VS,
    input  logic        Vde,
    input  logic [7:0]  R,
    input  logic [7:0]  G,
    input  logic [7:0]  B,
    output logic        pix_valid,
    output logic [11:0] x_pos,
    output logic [11:0] y_pos,
    output logic [7:0]  R_out,
    output logic [7:0]  G_out,
    output logic [7:0]  B_out,
    output logic        locked,
    output logic        timing_err,
    output logic [15:0] frame_sum,
    output logic        sum_valid
);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [12:0] c_h_total  = 13'(H_TOTAL);
    localparam logic [11:0] c_h_active = 12'(H_ACTIVE);
    localparam logic [11:0] c_v_total  = 12'(V_TOTAL);
    localparam logic [11:0] c_v_active = 12'(V_ACTIVE);
    localparam logic [11:0] c_sat      = 12'hFFF;
    // XOR with this turns a raw sync level into "asserted"
    localparam logic        c_pol      = (SYNC_ACTIVE_LOW != 0);

    state_t      r_state, w_state_n;
    logic        r_hs, r_vs, r_de, r_hs_d, r_vs_d;
    logic [7:0]  r_red, r_grn, r_blu;
    logic [11:0] r_line_clk, r_act_clk, r_line_num, r_act_lines;
    logic        r_acq_fail, w_acq_fail_n;
    logic        r_first_hs, w_first_hs_n;
    logic        w_err, w_sum_upd;
    logic [15:0] r_acc;

    logic w_hs_edge, w_vs_edge, w_len_bad, w_act_bad, w_hs_fail, w_vs_fail;
    logic w_fail, w_valid;

    assign w_hs_edge = (r_hs ^ c_pol) & ~(r_hs_d ^ c_pol);
    assign w_vs_edge = (r_vs ^ c_pol) & ~(r_vs_d ^ c_pol);

    // Line length measured in 13 bits so a saturated counter cannot wrap into a match
    assign w_len_bad = ({1'b0, r_line_clk} + 13'd1) != c_h_total;
    assign w_act_bad = (r_act_clk != 12'd0) && (r_act_clk != c_h_active);
    assign w_hs_fail = w_hs_edge & ((w_len_bad & ~r_first_hs) | w_act_bad);
    // Frame checks use the pre-update counts; a coincident HS edge is already folded in
    assign w_vs_fail = w_vs_edge & ((r_line_num != c_v_total) | (r_act_lines != c_v_active));
    assign w_fail    = w_hs_fail | w_vs_fail;

    assign locked  = (r_state == LOCKED);
    assign w_valid = r_de & locked;

    // Input stage: single register on every pin plus previous sync samples for edge detect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hs   <= 1'b0;
            r_vs   <= 1'b0;
            r_de   <= 1'b0;
            r_hs_d <= 1'b0;
            r_vs_d <= 1'b0;
            r_red  <= 8'd0;
            r_grn  <= 8'd0;
            r_blu  <= 8'd0;
        end else begin
            r_hs   <= HS;
            r_vs   <= VS;
            r_de   <= Vde;
            r_hs_d <= r_hs;
            r_vs_d <= r_vs;
            r_red  <= R;
            r_grn  <= G;
            r_blu  <= B;
        end
    end

    // Next-state logic for the lock FSM and its acquisition flags
    always_comb begin
        w_state_n    = r_state;
        w_acq_fail_n = r_acq_fail;
        w_first_hs_n = r_first_hs & ~w_hs_edge;
        w_err        = 1'b0;
        w_sum_upd    = 1'b0;
        case (r_state)
            SEARCH: begin
                if (w_vs_edge) begin
                    w_state_n    = ACQUIRE;
                    w_acq_fail_n = 1'b0;
                    w_first_hs_n = 1'b1;
                end
            end
            ACQUIRE: begin
                if (w_vs_edge) begin
                    w_acq_fail_n = 1'b0;
                    if (r_acq_fail | w_fail) begin
                        w_first_hs_n = 1'b1;
                    end else begin
                        w_state_n    = LOCKED;
                        w_first_hs_n = 1'b0;
                    end
                end else if (w_fail) begin
                    w_acq_fail_n = 1'b1;
                end
            end
            LOCKED: begin
                if (w_fail) begin
                    w_state_n    = ACQUIRE;
                    w_err        = 1'b1;
                    w_first_hs_n = 1'b1;
                    // Dropping out mid-frame leaves a partial frame that must not qualify a relock
                    w_acq_fail_n = ~w_vs_edge;
                end else if (w_vs_edge) begin
                    w_sum_upd = 1'b1;
                end
            end
            default: begin
                w_state_n = SEARCH;
            end
        endcase
    end

    // Lock FSM state and flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= SEARCH;
            r_acq_fail <= 1'b0;
            r_first_hs <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_acq_fail <= w_acq_fail_n;
            r_first_hs <= w_first_hs_n;
        end
    end

    // Line and frame timing counters, all saturating
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_line_clk  <= 12'd0;
            r_act_clk   <= 12'd0;
            r_line_num  <= 12'd0;
            r_act_lines <= 12'd0;
        end else begin
            if (w_hs_edge) begin
                r_line_clk <= 12'd0;
                r_act_clk  <= 12'd0;
            end else begin
                if (r_line_clk != c_sat) r_line_clk <= r_line_clk + 12'd1;
                if (r_de && (r_act_clk != c_sat)) r_act_clk <= r_act_clk + 12'd1;
            end
            if (w_vs_edge) begin
                r_line_num  <= w_hs_edge ? 12'd1 : 12'd0;
                r_act_lines <= 12'd0;
            end else if (w_hs_edge) begin
                if (r_line_num != c_sat) r_line_num <= r_line_num + 12'd1;
                if ((r_act_clk != 12'd0) && (r_act_lines != c_sat)) begin
                    r_act_lines <= r_act_lines + 12'd1;
                end
            end
        end
    end

    // Pixel output stage, error pulse and per-frame checksum
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_valid  <= 1'b0;
            x_pos      <= 12'd0;
            y_pos      <= 12'd0;
            R_out      <= 8'd0;
            G_out      <= 8'd0;
            B_out      <= 8'd0;
            timing_err <= 1'b0;
            sum_valid  <= 1'b0;
            frame_sum  <= 16'd0;
            r_acc      <= 16'd0;
        end else begin
            pix_valid  <= w_valid;
            x_pos      <= w_valid ? r_act_clk : 12'd0;
            y_pos      <= w_valid ? r_act_lines : 12'd0;
            R_out      <= r_red;
            G_out      <= r_grn;
            B_out      <= r_blu;
            timing_err <= w_err;
            sum_valid  <= w_sum_upd;
            if (w_sum_upd) frame_sum <= r_acc;
            if (w_vs_edge) begin
                r_acc <= 16'd0;
            end else if (w_valid) begin
                r_acc <= r_acc + 16'(r_red) + 16'(r_grn) + 16'(r_blu);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_sync_decoder
// Description : Directed self-checking bench for vga_sync_decoder. One DUT runs
//               a scaled 40x20 active-low timing, a second runs 16x8 active-high
//               timing with VS coincident with HS.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_sync_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        hs, vs, de;
    logic [7:0]  red, grn, blu;
    logic        pix_valid, locked, timing_err, sum_valid;
    logic [11:0] x_pos, y_pos;
    logic [7:0]  r_out, g_out, b_out;
    logic [15:0] frame_sum;

    logic        hs2, vs2, de2;
    logic [7:0]  c2;
    logic        pix_valid2, locked2, timing_err2, sum_valid2;
    logic [11:0] x_pos2, y_pos2;
    logic [7:0]  r_out2, g_out2, b_out2;
    logic [15:0] frame_sum2;

    vga_sync_decoder #(
        .H_TOTAL(40), .H_ACTIVE(32), .V_TOTAL(20), .V_ACTIVE(16), .SYNC_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .HS(hs), .VS(vs), .Vde(de), .R(red), .G(grn), .B(blu),
        .pix_valid(pix_valid), .x_pos(x_pos), .y_pos(y_pos),
        .R_out(r_out), .G_out(g_out), .B_out(b_out),
        .locked(locked), .timing_err(timing_err), .frame_sum(frame_sum), .sum_valid(sum_valid)
    );

    vga_sync_decoder #(
        .H_TOTAL(16), .H_ACTIVE(10), .V_TOTAL(8), .V_ACTIVE(5), .SYNC_ACTIVE_LOW(0)
    ) dut2 (
        .clk(clk), .rst(rst), .HS(hs2), .VS(vs2), .Vde(de2), .R(c2), .G(c2), .B(c2),
        .pix_valid(pix_valid2), .x_pos(x_pos2), .y_pos(y_pos2),
        .R_out(r_out2), .G_out(g_out2), .B_out(b_out2),
        .locked(locked2), .timing_err(timing_err2), .frame_sum(frame_sum2), .sum_valid(sum_valid2)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Per-frame observations of the first DUT, cleared when frame_id changes
    int frame_id = 0;
    int pix_cnt, sv_cnt, te_cnt, te_lock_bad, bad_x, bad_y, bad_zero, x_max, y_max;
    logic [15:0] last_sum;

    initial begin
        int mon_id;
        int run_x, run_y;
        mon_id = -1;
        run_x = 0;
        run_y = 0;
        forever begin
            @(negedge clk);
            if (mon_id != frame_id) begin
                mon_id = frame_id;
                pix_cnt = 0; sv_cnt = 0; te_cnt = 0; te_lock_bad = 0;
                bad_x = 0; bad_y = 0; bad_zero = 0; x_max = 0; y_max = 0;
                run_x = 0; run_y = 0;
            end
            if (pix_valid) begin
                if (int'(x_pos) != run_x) bad_x++;
                if (int'(y_pos) != run_y) bad_y++;
                if (int'(x_pos) > x_max) x_max = int'(x_pos);
                if (int'(y_pos) > y_max) y_max = int'(y_pos);
                run_x++;
                pix_cnt++;
            end else begin
                if (run_x != 0) begin
                    run_y++;
                    run_x = 0;
                end
                if ((x_pos != 12'd0) || (y_pos != 12'd0)) bad_zero++;
            end
            if (sum_valid) begin
                sv_cnt++;
                last_sum = frame_sum;
            end
            if (timing_err) begin
                te_cnt++;
                if (locked) te_lock_bad++;
            end
        end
    end

    // Per-frame observations of the second DUT
    int frame2_id = 0;
    int pix2, sv2, te2;
    logic [15:0] sum2;

    initial begin
        int mon2_id;
        mon2_id = -1;
        forever begin
            @(negedge clk);
            if (mon2_id != frame2_id) begin
                mon2_id = frame2_id;
                pix2 = 0; sv2 = 0; te2 = 0;
            end
            if (pix_valid2) pix2++;
            if (sum_valid2) begin
                sv2++;
                sum2 = frame_sum2;
            end
            if (timing_err2) te2++;
        end
    end

    logic        lk_before, lk_after, lk2_start;
    logic [63:0] rs_a, rs_b;

    // One 40x20 frame: Vde x0..31 on lines 0..15, HS low x34..37, VS low lines 17..18
    task automatic frame1(input int short_line, input int de_short_line, input int rst_line,
                          input logic [7:0] cr, input logic [7:0] cg, input logic [7:0] cb);
        frame_id++;
        for (int ln = 0; ln < 20; ln++) begin
            for (int x = 0; x < 40; x++) begin
                if (!(ln == short_line && x == 39)) begin
                    @(posedge clk);
                    #1;
                    if (ln == 16 && x == 0) lk_before = locked;
                    if (ln == 18 && x == 0) lk_after = locked;
                    if (ln == rst_line) begin
                        if (x == 5) rst = 1'b1;
                        if (x == 8) begin
                            rs_a = {24'd0, frame_sum, x_pos, y_pos};
                            rs_b = {36'd0, r_out, g_out, b_out, pix_valid, locked, timing_err, sum_valid};
                        end
                        if (x == 10) rst = 1'b0;
                    end
                    de  = (ln < 16) && (x < ((ln == de_short_line) ? 31 : 32));
                    hs  = !(x >= 34 && x < 38);
                    vs  = !(ln >= 17 && ln < 19);
                    red = cr;
                    grn = cg;
                    blu = cb;
                end
            end
        end
    endtask

    // One 16x8 frame: HS high x0..1, VS high lines 0..1 (edge shared with HS), Vde x3..12 on lines 2..6
    task automatic frame2(input logic [7:0] c);
        frame2_id++;
        for (int ln = 0; ln < 8; ln++) begin
            for (int x = 0; x < 16; x++) begin
                @(posedge clk);
                #1;
                if (ln == 0 && x == 4) lk2_start = locked2;
                hs2 = (x < 2);
                vs2 = (ln < 2);
                de2 = (ln >= 2) && (ln <= 6) && (x >= 3) && (x <= 12);
                c2  = c;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        hs = 1'b1; vs = 1'b1; de = 1'b0; red = 8'd0; grn = 8'd0; blu = 8'd0;
        hs2 = 1'b0; vs2 = 1'b0; de2 = 1'b0; c2 = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_a", {24'd0, frame_sum, x_pos, y_pos}, 64'd0);
        check_val("reset_b", {36'd0, r_out, g_out, b_out, pix_valid, locked, timing_err, sum_valid}, 64'd0);
        check_val("reset_lock2", {63'd0, locked2}, 64'd0);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Frame 0: first VS edge only enters acquisition
        frame1(-1, -1, -1, 8'd1, 8'd1, 8'd1);
        check_val("f0_locked", {63'd0, lk_after}, 64'd0);
        // Frame 1: clean frame, lock rises on the second VS edge
        frame1(-1, -1, -1, 8'd1, 8'd1, 8'd1);
        check_val("f1_lock_pre", {63'd0, lk_before}, 64'd0);
        check_val("f1_lock_post", {63'd0, lk_after}, 64'd1);
        check_val("f1_pix", pix_cnt, 0);
        // Frame 2: full locked frame, checksum wraps: 350*512 mod 65536
        frame1(-1, -1, -1, 8'd200, 8'd100, 8'd50);
        check_val("f2_pix", pix_cnt, 512);
        check_val("f2_xseq", bad_x, 0);
        check_val("f2_yseq", bad_y, 0);
        check_val("f2_idle_xy", bad_zero, 0);
        check_val("f2_xmax", x_max, 31);
        check_val("f2_ymax", y_max, 15);
        check_val("f2_sv", sv_cnt, 1);
        check_val("f2_sum", last_sum, 48128);
        check_val("f2_te", te_cnt, 0);
        // Frame 3: constant colour 1 -> 3*512
        frame1(-1, -1, -1, 8'd1, 8'd1, 8'd1);
        check_val("f3_sv", sv_cnt, 1);
        check_val("f3_sum", last_sum, 1536);
        // Frame 4: line 5 one clock short
        frame1(5, -1, -1, 8'd1, 8'd1, 8'd1);
        check_val("short_te", te_cnt, 1);
        check_val("short_te_lock", te_lock_bad, 0);
        check_val("short_sv", sv_cnt, 0);
        check_val("short_lock1", {63'd0, lk_after}, 64'd0);
        // Frame 5: relock at the second VS edge after the error
        frame1(-1, -1, -1, 8'd1, 8'd1, 8'd1);
        check_val("relock_pre", {63'd0, lk_before}, 64'd0);
        check_val("relock_post", {63'd0, lk_after}, 64'd1);
        check_val("relock_te", te_cnt, 0);
        frame1(-1, -1, -1, 8'd1, 8'd1, 8'd1);
        check_val("f6_sum", last_sum, 1536);
        // Frame 7: Vde one clock short on line 3
        frame1(-1, 3, -1, 8'd1, 8'd1, 8'd1);
        check_val("de_te", te_cnt, 1);
        check_val("de_sv", sv_cnt, 0);
        check_val("de_lock", {63'd0, lk_after}, 64'd0);
        frame1(-1, -1, -1, 8'd1, 8'd1, 8'd1);
        check_val("f8_lock", {63'd0, lk_after}, 64'd1);
        // Frame 9: reset pulsed on line 8 while locked
        frame1(-1, -1, 8, 8'd1, 8'd1, 8'd1);
        check_val("midrst_a", rs_a, 64'd0);
        check_val("midrst_b", rs_b, 64'd0);
        check_val("midrst_lock", {63'd0, lk_after}, 64'd0);
        frame1(-1, -1, -1, 8'd1, 8'd1, 8'd1);
        check_val("postrst_pre", {63'd0, lk_before}, 64'd0);
        check_val("postrst_post", {63'd0, lk_after}, 64'd1);
        frame1(-1, -1, -1, 8'd200, 8'd100, 8'd50);
        check_val("f11_pix", pix_cnt, 512);
        check_val("f11_sum", last_sum, 48128);

        // Second DUT: active-high syncs with coincident VS/HS edges
        hs = 1'b1; vs = 1'b1; de = 1'b0;
        frame2(8'd7);
        check_val("s0_lock", {63'd0, lk2_start}, 64'd0);
        frame2(8'd7);
        check_val("s1_lock", {63'd0, lk2_start}, 64'd1);
        check_val("s1_pix", pix2, 50);
        frame2(8'd7);
        check_val("s2_lock", {63'd0, lk2_start}, 64'd1);
        check_val("s2_sv", sv2, 1);
        check_val("s2_sum", sum2, 1050);
        check_val("s2_pix", pix2, 50);
        frame2(8'd7);
        check_val("s3_lock", {63'd0, lk2_start}, 64'd1);
        check_val("s3_te", te2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 Parameter H_TOTAL, default 800: expected clocks per line.
REQ-002 Parameter H_ACTIVE, default 640: expected Vde-high clocks per active line.
REQ-003 Parameter V_TOTAL, default 525: expected lines per frame.
REQ-004 Parameter V_ACTIVE, default 480: expected active lines per frame.
REQ-005 Parameter SYNC_ACTIVE_LOW, default 1: 1 means HS/VS are asserted low; 0 means asserted high.
REQ-006 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-007 clk  input  1  pixel clock; all logic on rising edge.
REQ-008 rst  input  1  asynchronous active-high reset.
REQ-009 HS, VS, Vde  input  1 each  horizontal sync, vertical sync, data enable.
REQ-010 R, G, B  input  8 each  pixel colour.
REQ-011 pix_valid  output  1  registered Vde, gated by lock.
REQ-012 x_pos, y_pos  output  12 each  active pixel column and active line index.
REQ-013 R_out, G_out, B_out  output  8 each  registered colour aligned with pix_valid.
REQ-014 locked  output  1  timing matches parameters.
REQ-015 timing_err  output  1  one-clock pulse on detected mismatch while locked.
REQ-016 frame_sum  output  16  per-frame colour checksum; sum_valid  output  1  one-clock pulse when frame_sum updates.

Function
REQ-017 Input stage: HS, VS, Vde, R, G, B SHALL be registered once; all decoding uses the registered copies.
REQ-018 Sync edges: a leading edge is a transition into the asserted level per SYNC_ACTIVE_LOW, detected against the previous registered sample.
REQ-019 Counters: line_clk (12 b) counts clocks since the last HS edge; act_clk (12 b) counts Vde clocks in the current line; line_num and act_lines (12 b each) count frame lines and active lines; all counters saturate at 4095.
REQ-020 On each HS edge: check line_clk+1 == H_TOTAL (skipped for the first HS edge after entering ACQUIRE) and act_clk in {0, H_ACTIVE}; increment act_lines if act_clk != 0; then clear line_clk and act_clk.
REQ-021 On a VS edge: check line_num == V_TOTAL and act_lines == V_ACTIVE; then set line_num to 1 if an HS edge occurs on the same clock, else 0; clear act_lines; otherwise each HS edge increments line_num.
REQ-022 FSM states: SEARCH, ACQUIRE, LOCKED; SEARCH -> ACQUIRE on the first VS edge.
REQ-023 ACQUIRE: a failed check sets a sticky fail flag; at the next VS edge, go to LOCKED if no check failed since entry, else restart ACQUIRE with the flag cleared.
REQ-024 LOCKED: any failed check SHALL pulse timing_err for one clock and move to ACQUIRE on the same clock; locked = (state == LOCKED).
REQ-025 Data path: pix_valid, x_pos, y_pos, R_out, G_out, B_out appear 2 clocks after the input-pin sample; pix_valid = Vde_reg and LOCKED.
REQ-026 x_pos = act_clk before increment; y_pos = act_lines of the current line; both read 0 when pix_valid = 0.
REQ-027 Checksum accumulator (16 b, wraps mod 65536) adds R+G+B on each pix_valid clock; on a VS edge in LOCKED with all checks passing, frame_sum <= accumulator, sum_valid pulses for one clock, and the accumulator clears; on every other VS edge the accumulator clears without an update.
REQ-028 Simultaneous HS and VS edges: the HS checks evaluate first, then the VS checks; either failure counts as a single error (one timing_err pulse).

Reset
REQ-029 While rst = 1: state = SEARCH; all counters, registered inputs, outputs, frame_sum and the accumulator SHALL be 0.
REQ-030 Reset asserted mid-frame SHALL take effect immediately; after release, locking SHALL require a fresh VS edge followed by one clean full frame.

Verification
REQ-031 Nominal 800x525 stream from reset: locked rises on the 2nd VS edge (end of first full frame); pix_valid yields exactly 640x480 clocks per frame; x_pos runs 0..639 and y_pos runs 0..479.
REQ-032 Constant colour R=G=B=1 while locked: frame_sum = (3*307200) mod 65536 = 4096, with one sum_valid pulse per frame.
REQ-033 Locked, then one line shortened to 799 clocks: one timing_err pulse at that HS edge; locked falls on the same clock; relock at the 2nd following VS edge.
REQ-034 Locked, then Vde high for 639 clocks on one line: timing_err pulses; no sum_valid at the next VS edge.
REQ-035 Bench override H_TOTAL=16, H_ACTIVE=10, V_TOTAL=8, V_ACTIVE=5, SYNC_ACTIVE_LOW=0, with VS edges coincident with HS edges: locks after one frame; line_num counts exactly 8 per frame.
REQ-036 rst pulsed mid-frame while locked: all outputs are 0 during reset; locked stays 0 until one full clean frame after the next VS edge.
